bram_arbiter: RTL
=================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning BRAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, meaning BRAM data width.
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port i_areset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 For k in {0,1}, the block SHALL have port i_req<k>, input, 1 bit, access request held until acknowledged.
REQ-006 For k in {0,1}, the block SHALL have port i_we<k>, input, 1 bit, write (1) or read (0).
REQ-007 For k in {0,1}, the block SHALL have port i_addr<k>, input, ADDR_WIDTH bits, access address.
REQ-008 For k in {0,1}, the block SHALL have port i_wdata<k>, input, DATA_WIDTH bits, write data.
REQ-009 For k in {0,1}, the block SHALL have port o_ack<k>, output, 1 bit, request accepted this cycle.
REQ-010 For k in {0,1}, the block SHALL have port o_rvalid<k>, output, 1 bit, read data valid.
REQ-011 For k in {0,1}, the block SHALL have port o_rdata<k>, output, DATA_WIDTH bits, read data.
REQ-012 The block SHALL have port o_bram_addr, output, ADDR_WIDTH bits, to BRAM i_addr.
REQ-013 The block SHALL have port o_bram_write, output, 1 bit, to BRAM i_write.
REQ-014 The block SHALL have port o_bram_wdata, output, DATA_WIDTH bits, to BRAM i_data.
REQ-015 The block SHALL have port i_bram_rdata, input, DATA_WIDTH bits, from BRAM o_data (registered, 1-cycle read).

Function
REQ-016 The block SHALL issue at most one BRAM access per cycle.
REQ-017 o_ack<k> SHALL be combinational; a handshake completes on the edge where i_req<k> and o_ack<k> are both 1; at most one ack is high per cycle.
REQ-018 The accepted command SHALL be registered onto o_bram_addr/o_bram_write/o_bram_wdata in the cycle after the handshake (cycle N+1).
REQ-019 In a cycle with no accepted command, o_bram_write SHALL be 0 and o_bram_addr/o_bram_wdata SHALL hold their previous values.
REQ-020 For a read accepted in cycle N, o_rvalid<k> SHALL be 1 for exactly cycle N+2 with o_rdata<k> = i_bram_rdata; latency is fixed at 2.
REQ-021 A 2-stage valid/port tag pipeline SHALL track in-flight reads; back-to-back reads from either port SHALL sustain one access per cycle.
REQ-022 o_rdata<k> SHALL be don't-care when o_rvalid<k> is 0; writes SHALL never produce o_rvalid.
REQ-023 When only one port requests, that port SHALL be acked in the same cycle.
REQ-024 When both ports request, the winner SHALL be the port holding priority; the loser waits with its request held stable.
REQ-025 Priority pointer: after port k wins a contended cycle, port 1-k SHALL hold priority; an uncontended grant SHALL leave the pointer unchanged.
REQ-026 Ordering: an access accepted before another SHALL reach the BRAM first; a read at N+1 after a write to the same address at N SHALL return the new data.

Reset
REQ-027 While i_areset_n is 0: o_bram_write=0, o_bram_addr=0, o_bram_wdata=0, pipeline valids cleared, o_rvalid0/1=0, pointer set to port 0.
REQ-028 o_ack<k> SHALL be 0 during reset regardless of i_req<k>.
REQ-029 Reads in flight when reset asserts SHALL be discarded and produce no o_rvalid after release.

Configuration
REQ-030 With macro BRAM_ARBITER_ROUND_ROBIN_EN defined, priority SHALL follow REQ-025.
REQ-031 Without BRAM_ARBITER_ROUND_ROBIN_EN, port 0 SHALL always win contention and no pointer register SHALL exist.

Verification
REQ-032 Port 0 write addr 0x00 data 0xdeadbeef00000000, then read addr 0x00 -> o_rvalid0 two cycles after the read ack, o_rdata0=0xdeadbeef00000000.
REQ-033 Both ports read simultaneously for 4 cycles, round-robin on -> acks alternate 0,1,0,1; rvalids alternate with correct data; macro off -> port 0 acked all 4 cycles.
REQ-034 Port 1 writes 0xabad1deac0fef00d to 0x01 in cycle N, port 0 reads 0x01 in cycle N+1 -> o_rdata0=0xabad1deac0fef00d at N+3.
REQ-035 Idle cycles between accesses -> o_bram_write=0 and o_bram_addr unchanged.
REQ-036 Assert i_areset_n=0 one cycle after a read ack -> no o_rvalid after release; pointer back to port 0.

Source files
------------

// File: rtl/bram_arbiter.sv
// bram_arbiter: two-port arbiter sharing one single-port BRAM with a fixed 2-cycle read latency.
// Optional macro BRAM_ARBITER_ROUND_ROBIN_EN: alternate priority after contended grants;
// when undefined, port 0 always wins contention.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_req0,
  input  logic                  i_we0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  input  logic [DATA_WIDTH-1:0] i_wdata0,
  output logic                  o_ack0,
  output logic                  o_rvalid0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic                  i_we1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  input  logic [DATA_WIDTH-1:0] i_wdata1,
  output logic                  o_ack1,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic                  o_bram_write,
  output logic [DATA_WIDTH-1:0] o_bram_wdata,
  input  logic [DATA_WIDTH-1:0] i_bram_rdata
);
  logic                  prio;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic                  bram_write_q, bram_write_d;
  logic [DATA_WIDTH-1:0] bram_wdata_q, bram_wdata_d;
  logic                  v1_q, v1_d, p1_q, p1_d;
  logic                  v2_q, v2_d, p2_q, p2_d;

`ifdef BRAM_ARBITER_ROUND_ROBIN_EN
  logic prio_q, prio_d;
  assign prio = prio_q;
  // Contended grants hand priority to the other port; uncontended grants leave it alone
  always_comb prio_d = (o_ack0 | o_ack1) && i_req0 && i_req1 ? ~prio_q : prio_q;
  // Priority pointer register, port 0 after reset
  always_ff @(posedge i_clk or negedge i_areset_n)
    if (!i_areset_n) prio_q <= 1'b0;
    else             prio_q <= prio_d;
`else
  assign prio = 1'b0;
`endif

  // Combinational grant; nothing is acked while reset is held
  always_comb begin
    o_ack0 = i_areset_n & i_req0 & (~i_req1 | ~prio);
    o_ack1 = i_areset_n & i_req1 & (~i_req0 | prio);
  end

  // Capture the accepted command for the BRAM and tag reads entering the latency pipeline
  always_comb begin
    bram_addr_d  = o_ack1 ? i_addr1  : o_ack0 ? i_addr0  : bram_addr_q;
    bram_wdata_d = o_ack1 ? i_wdata1 : o_ack0 ? i_wdata0 : bram_wdata_q;
    bram_write_d = o_ack1 ? i_we1    : o_ack0 ? i_we0    : 1'b0;
    v1_d         = (o_ack1 & ~i_we1) | (o_ack0 & ~i_we0);
    p1_d         = o_ack1;
    v2_d         = v1_q;
    p2_d         = p1_q;
  end

  // Command and read-tag registers
  always_ff @(posedge i_clk or negedge i_areset_n)
    if (!i_areset_n) begin
      bram_addr_q  <= '0;
      bram_write_q <= 1'b0;
      bram_wdata_q <= '0;
      v1_q         <= 1'b0;
      p1_q         <= 1'b0;
      v2_q         <= 1'b0;
      p2_q         <= 1'b0;
    end else begin
      bram_addr_q  <= bram_addr_d;
      bram_write_q <= bram_write_d;
      bram_wdata_q <= bram_wdata_d;
      v1_q         <= v1_d;
      p1_q         <= p1_d;
      v2_q         <= v2_d;
      p2_q         <= p2_d;
    end

  assign o_bram_addr  = bram_addr_q;
  assign o_bram_write = bram_write_q;
  assign o_bram_wdata = bram_wdata_q;
  assign o_rvalid0    = v2_q & ~p2_q;
  assign o_rvalid1    = v2_q & p2_q;
  assign o_rdata0     = i_bram_rdata;
  assign o_rdata1     = i_bram_rdata;
endmodule
